// File: rtl/zx_clock_contend.sv
// ZX48-family CPU clock-enable generator and ULA contention controller.
// Divides the 28 MHz master clock into enable strobes and stalls the CPU during video fetch.
module zx_clock_contend #(
  parameter int MODEL    = 0,
  parameter int TURBO_EN = 1,
  parameter int IOCONT   = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [1:0]  i_turbo,
  input  logic        i_de,
  input  logic [2:0]  i_hc,
  input  logic        i_mreq,
  input  logic        i_iorq,
  input  logic [15:0] i_a,
  input  logic [2:0]  i_bank,
  output logic        o_ce14p,
  output logic        o_ce14n,
  output logic        o_ce70p,
  output logic        o_ce70n,
  output logic        o_ce35p,
  output logic        o_ce35n,
  output logic        o_ce17p,
  output logic        o_ce17n,
  output logic        o_cpu_cep,
  output logic        o_cpu_cen,
  output logic        o_contend
);

  logic [3:0] r_c;
  logic [1:0] r_speed;
  logic       r_mreq_s;
  logic       r_iorq_s;
  logic       r_contend_d;
  logic       r_ce14p, r_ce14n, r_ce70p, r_ce70n;
  logic       r_ce35p, r_ce35n, r_ce17p, r_ce17n;

  logic [1:0] w_turbo_req;
  logic       w_pe;
  logic       w_ne;
  logic       w_cont_addr;
  logic       w_window;
  logic       w_mcont;
  logic       w_icont;
  logic       w_unused;

  assign w_unused = ^{i_bank[1], i_a[13:1]};

  // Reserved speed code 3 behaves as the stock 3.5 MHz rate.
  assign w_turbo_req = (TURBO_EN != 0 && i_turbo != 2'd3) ? i_turbo : 2'd0;

  always_comb begin
    w_pe = r_ce35n;
    w_ne = r_ce35p;
    case (r_speed)
      2'd1: begin
        w_pe = r_ce70n;
        w_ne = r_ce70p;
      end
      2'd2: begin
        w_pe = r_ce14n;
        w_ne = r_ce14p;
      end
      default: begin
        w_pe = r_ce35n;
        w_ne = r_ce35p;
      end
    endcase
  end

  always_comb begin
    w_cont_addr = (i_a[15:14] == 2'b01);
    if (MODEL == 1)
      w_cont_addr = (i_a[15:14] == 2'b01) || (i_a[15:14] == 2'b11 && i_bank[0]);
    else if (MODEL == 2)
      w_cont_addr = (i_a[15:14] == 2'b01) || (i_a[15:14] == 2'b11 && i_bank[2]);
  end

  always_comb begin
    if (MODEL == 2)
      w_window = (i_hc != 3'd1);
    else
      w_window = (i_hc <= 3'd5);
  end

  // The _s samples only move on cpu_cep, so a stalled request keeps its "new" qualifier.
  assign w_mcont = ~i_mreq & w_cont_addr & r_mreq_s;
  assign w_icont = (IOCONT != 0 && MODEL < 2) ?
                   (~i_iorq & r_iorq_s & (~i_a[0] | w_cont_addr)) : 1'b0;

  assign o_contend = (r_speed == 2'd0) & i_de & w_window & (w_mcont | w_icont);

  // A falling half-cycle that began before the stall is allowed to complete.
  assign o_cpu_cep = w_pe & ~o_contend;
  assign o_cpu_cen = w_ne & (~o_contend | r_contend_d);

  assign o_ce14p = r_ce14p;
  assign o_ce14n = r_ce14n;
  assign o_ce70p = r_ce70p;
  assign o_ce70n = r_ce70n;
  assign o_ce35p = r_ce35p;
  assign o_ce35n = r_ce35n;
  assign o_ce17p = r_ce17p;
  assign o_ce17n = r_ce17n;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_c         <= 4'd0;
      r_speed     <= 2'd0;
      r_mreq_s    <= 1'b1;
      r_iorq_s    <= 1'b1;
      r_contend_d <= 1'b0;
      r_ce14p     <= 1'b0;
      r_ce14n     <= 1'b0;
      r_ce70p     <= 1'b0;
      r_ce70n     <= 1'b0;
      r_ce35p     <= 1'b0;
      r_ce35n     <= 1'b0;
      r_ce17p     <= 1'b0;
      r_ce17n     <= 1'b0;
    end else begin
      r_c     <= r_c + 4'd1;
      r_ce14n <= ~r_c[0];
      r_ce14p <= r_c[0];
      r_ce70n <= (r_c[1:0] == 2'b00);
      r_ce70p <= (r_c[1:0] == 2'b10);
      r_ce35n <= (r_c[2:0] == 3'b000);
      r_ce35p <= (r_c[2:0] == 3'b100);
      r_ce17n <= (r_c == 4'd0);
      r_ce17p <= (r_c == 4'd8);
      // Speed only changes on a 3.5 MHz boundary so no CPU period is ever split.
      if (r_c[2:0] == 3'b000)
        r_speed <= w_turbo_req;
      if (o_cpu_cep) begin
        r_mreq_s <= i_mreq;
        r_iorq_s <= i_iorq;
      end
      if (r_ce14p)
        r_contend_d <= o_contend;
    end
  end

endmodule

// File: tb/tb_zx_clock_contend.sv
// Bench for zx_clock_contend: one instance per timing model, driven from shared stimulus.
// Expected stall lengths and strobe counts go through a scoreboard queue.
module tb_zx_clock_contend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  turbo = 2'd0;
  logic        de = 1'b0;
  logic [2:0]  hc = 3'd0;
  logic        mreq = 1'b1;
  logic        iorq = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [2:0]  bank = 3'd0;

  logic [2:0] ce14p, ce14n, ce70p, ce70n, ce35p, ce35n, ce17p, ce17n;
  logic [2:0] cep, cen, contend;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    zx_clock_contend #(.MODEL(g), .TURBO_EN(1), .IOCONT(1)) u_dut (
      .i_clock  (clk),
      .i_reset  (rst),
      .i_turbo  (turbo),
      .i_de     (de),
      .i_hc     (hc),
      .i_mreq   (mreq),
      .i_iorq   (iorq),
      .i_a      (a),
      .i_bank   (bank),
      .o_ce14p  (ce14p[g]),
      .o_ce14n  (ce14n[g]),
      .o_ce70p  (ce70p[g]),
      .o_ce70n  (ce70n[g]),
      .o_ce35p  (ce35p[g]),
      .o_ce35n  (ce35n[g]),
      .o_ce17p  (ce17p[g]),
      .o_ce17n  (ce17n[g]),
      .o_cpu_cep(cep[g]),
      .o_cpu_cen(cen[g]),
      .o_contend(contend[g])
    );
  end

  logic [9:0] vec0;
  logic       any_en;
  assign vec0 = {ce14p[0], ce14n[0], ce70p[0], ce70n[0], ce35p[0], ce35n[0],
                 ce17p[0], ce17n[0], cep[0], cen[0]};
  assign any_en = |{ce14p, ce14n, ce70p, ce70n, ce35p, ce35n, ce17p, ce17n, cep, cen};

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_dec8(input int k);
    do tick(); while (((cyc - 1) % 8) != k);
  endtask

  // Mid T-state: advance the video counter for the next 3.5 MHz slot.
  task automatic step_t();
    wait_dec8(4);
    hc = hc + 3'd1;
  endtask

  function automatic int exp_strobes(input int d);
    logic [3:0] c;
    logic s14p, s14n, s70p, s70n, s35p, s35n, s17p, s17n;
    c = d[3:0];
    s14p = c[0];
    s14n = !c[0];
    s70p = (c[1:0] == 2'd2);
    s70n = (c[1:0] == 2'd0);
    s35p = (c[2:0] == 3'd4);
    s35n = (c[2:0] == 3'd0);
    s17p = (c == 4'd8);
    s17n = (c == 4'd0);
    return int'({s14p, s14n, s70p, s70n, s35p, s35n, s17p, s17n, s35n, s35p});
  endfunction

  function automatic int exp_stall(input int m, input logic [15:0] ad, input logic [2:0] bk,
                                   input bit io, input bit de_v, input logic [2:0] h);
    bit ca;
    bit hit;
    ca = (ad[15:14] == 2'b01) ||
         (m == 1 && ad[15:14] == 2'b11 && bk[0]) ||
         (m == 2 && ad[15:14] == 2'b11 && bk[2]);
    hit = io ? (m != 2 && (!ad[0] || ca)) : ca;
    if (!hit || !de_v) return 0;
    if (m == 2) begin
      if (h == 3'd1) return 0;
      if (h == 3'd0) return 1;
      return 9 - int'(h);
    end
    return (h <= 3'd5) ? 6 - int'(h) : 0;
  endfunction

  task automatic run_access(input string tag, input logic [15:0] addr, input logic [2:0] bk,
                            input bit io, input bit de_v, input logic [2:0] h0);
    int  stall[3];
    bit  done[3];
    logic [2:0] got;
    mreq = 1'b1;
    iorq = 1'b1;
    de   = de_v;
    a    = addr;
    bank = bk;
    step_t();
    step_t();
    for (int k = 0; k < 8 && hc != h0; k++) step_t();
    if (io) iorq = 1'b0;
    else    mreq = 1'b0;
    for (int m = 0; m < 3; m++) begin
      sb_q.push_back(exp_stall(m, addr, bk, io, de_v, h0));
      stall[m] = 0;
      done[m]  = 1'b0;
    end
    for (int t = 0; t < 12; t++) begin
      wait_dec8(0);
      got = cep;
      for (int m = 0; m < 3; m++)
        if (!done[m]) begin
          if (got[m]) done[m] = 1'b1;
          else        stall[m]++;
        end
      if (done[0] && done[1] && done[2]) break;
      step_t();
    end
    mreq = 1'b1;
    iorq = 1'b1;
    for (int m = 0; m < 3; m++)
      check_eq($sformatf("%s_m%0d", tag, m), stall[m], sb_q.pop_front());
    step_t();
    step_t();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int anyc;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", int'(vec0), 0);
    rst = 1'b1;
    cyc = 0;

    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq($sformatf("strobes_d%0d", (cyc - 1) % 16), int'(vec0), exp_strobes((cyc - 1) % 16));
    end

    run_access("mem4000_hc0", 16'h4000, 3'd0, 1'b0, 1'b1, 3'd0);
    run_access("mem4000_hc6", 16'h4000, 3'd0, 1'b0, 1'b1, 3'd6);
    run_access("mem8000_hc0", 16'h8000, 3'd0, 1'b0, 1'b1, 3'd0);
    run_access("memC000_b5",  16'hC000, 3'd5, 1'b0, 1'b1, 3'd2);
    run_access("memC000_b2",  16'hC000, 3'd2, 1'b0, 1'b1, 3'd2);
    run_access("io00FE_hc0",  16'h00FE, 3'd0, 1'b1, 1'b1, 3'd0);
    run_access("io00FF_hc3",  16'h00FF, 3'd0, 1'b1, 1'b1, 3'd3);
    run_access("io40FF_hc3",  16'h40FF, 3'd0, 1'b1, 1'b1, 3'd3);
    run_access("mem4000_de0", 16'h4000, 3'd0, 1'b0, 1'b0, 3'd0);

    // Turbo request lands mid-period; rate must hold until the next 3.5 MHz boundary.
    de = 1'b1;
    do tick(); while ((cyc % 16) != 3);
    turbo = 2'd2;
    sb_q.push_back(0);
    cnt = 0;
    repeat (5) begin tick(); cnt += int'(cep[0]); end
    check_eq("turbo_pre_boundary", cnt, sb_q.pop_front());
    sb_q.push_back(4);
    cnt = 0;
    repeat (8) begin tick(); cnt += int'(cep[0]); end
    check_eq("turbo_post_boundary", cnt, sb_q.pop_front());

    hc = 3'd0;
    a = 16'h4000;
    bank = 3'd0;
    mreq = 1'b0;
    sb_q.push_back(8);
    cnt = 0;
    anyc = 0;
    repeat (16) begin tick(); cnt += int'(cep[1]); anyc |= int'(|contend); end
    check_eq("turbo_contend", anyc, 0);
    check_eq("turbo_cep_count", cnt, sb_q.pop_front());
    mreq = 1'b1;

    turbo = 2'd3;
    repeat (16) tick();
    sb_q.push_back(2);
    cnt = 0;
    repeat (16) begin tick(); cnt += int'(cep[0]); end
    check_eq("turbo3_as_35", cnt, sb_q.pop_front());
    turbo = 2'd0;

    // Reset in the middle of a stall.
    de = 1'b1;
    a = 16'h4000;
    step_t();
    step_t();
    for (int k = 0; k < 8 && hc != 3'd2; k++) step_t();
    mreq = 1'b0;
    wait_dec8(0);
    check_eq("stall_before_reset", int'(cep[0]), 0);
    check_eq("contend_before_reset", int'(contend[0]), 1);
    tick();
    rst = 1'b0;
    #1;
    check_eq("reset_mid_stall", int'(any_en), 0);
    mreq = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    tick();
    check_eq("post_reset_first_cep", int'(cep[0]), 1);
    sb_q.push_back(1);
    cnt = 0;
    repeat (15) begin tick(); cnt += int'(cep[0]); end
    check_eq("post_reset_rate", cnt, sb_q.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
